data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words of storage; word index = req_addr[31:2].
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra wait states per access, range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: the core presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 3: instruction funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
REQ-009 SHALL have port req_addr, input, 32: byte address, little-endian.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned in rs2 format.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: the core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32: load result, already sign- or zero-extended.
REQ-014 SHALL have port rsp_err, output, 1: access faulted; qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, latching we, size, addr and wdata.
REQ-017 On acceptance SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES > 0, or directly to RESP when WAIT_CYCLES = 0.
REQ-018 In WAIT SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 0.
REQ-019 Latency: for acceptance at edge k, rsp_valid SHALL be high from edge k+WAIT_CYCLES onward (registered output).
REQ-020 SHALL perform the memory write and capture the read data on the edge that enters RESP, so a load accepted after a store's response observes the stored data.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge with rsp_valid cleared.
REQ-022 SHALL NOT accept a new request in the same cycle as a response handshake; there is no back-to-back overlap.
REQ-023 SB SHALL write byte addr[1:0] with wdata[7:0].
REQ-024 SH SHALL write half addr[1] with wdata[15:0].
REQ-025 SW SHALL write the full word; all other bytes of the addressed word SHALL be unchanged.
REQ-026 LB and LH SHALL sign-extend the selected byte or half to 32 bits.
REQ-027 LBU and LHU SHALL zero-extend the selected byte or half to 32 bits.
REQ-028 LW SHALL return the word unchanged.
REQ-029 SHALL set rsp_err = 1 on any of these faults: half access with addr[0] = 1; word access with addr[1:0] != 00; undefined size code (load 011/110/111, store 011..111); word index >= DEPTH_WORDS.
REQ-030 On a faulted access SHALL suppress the memory write, force rsp_rdata = 0, and still complete the normal handshake and latency.
REQ-031 For stores SHALL drive rsp_rdata = 0.
REQ-032 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-033 On rst_n = 0 SHALL asynchronously force: state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-034 Reset mid-operation (WAIT or RESP) SHALL abort the access; if reset precedes the RESP-entry edge, no write occurs.
REQ-035 Memory contents SHALL NOT be affected by reset.
REQ-036 After rst_n rises, the first request SHALL be accepted on the first rising edge with req_valid = 1.

Verification
REQ-037 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (WAIT_CYCLES = 1) -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid one edge after acceptance.
REQ-038 After REQ-037, SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-039 LH addr 0x13 -> rsp_err = 1, rsp_rdata = 0; SW addr 0x12 -> rsp_err = 1 and word 0x10 unchanged.
REQ-040 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata held stable and req_ready = 0; then rsp_ready = 1 -> IDLE next edge.
REQ-041 Assert rst_n = 0 during WAIT of SW 0x20 = 0x12345678 -> outputs reset immediately; a later LW 0x20 returns the prior value.
REQ-042 With DEPTH_WORDS = 256, LW addr 0x400 -> rsp_err = 1; with WAIT_CYCLES = 0, rsp_valid is high on the edge right after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store data memory responder: valid/ready request, fixed wait states, registered response.
// Byte-addressed little-endian storage with RV32 size decoding, sign/zero extension and fault reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          enter_resp;

    logic          lat_we;
    logic [2:0]    lat_size;
    logic [31:0]   lat_addr, lat_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          a_we;
    logic [2:0]    a_size;
    logic [31:0]   a_addr, a_wdata;
    logic [AW-1:0] idx;
    logic          size_ok, oob, err;
    logic [4:0]    bsh, hsh;
    logic [31:0]   rd_word, bsel, hsel, load_data, wmask, wsh, merged;
    logic          mem_we;

    // Next-state and wait counter
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end else begin
                    next_cnt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the access resolves on the accept edge, so use live inputs in IDLE
    always_comb begin
        a_we    = (state == IDLE) ? req_we    : lat_we;
        a_size  = (state == IDLE) ? req_size  : lat_size;
        a_addr  = (state == IDLE) ? req_addr  : lat_addr;
        a_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        idx     = a_addr[AW+1:2];
        oob     = 32'(a_addr[31:2]) >= DEPTH_WORDS;
        size_ok = 1'b0;
        case (a_size)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !a_we;
            default:                size_ok = 1'b0;
        endcase
        err = !size_ok || oob
            || ((a_size[1:0] == 2'b01) && a_addr[0])
            || ((a_size[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
    end

    // Lane selection, extension and store merge
    always_comb begin
        bsh     = {a_addr[1:0], 3'b000};
        hsh     = {a_addr[1], 4'b0000};
        rd_word = mem[idx];
        bsel    = rd_word >> bsh;
        hsel    = rd_word >> hsh;
        case (a_size)
            3'b000:  load_data = {{24{bsel[7]}}, bsel[7:0]};
            3'b001:  load_data = {{16{hsel[15]}}, hsel[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, bsel[7:0]};
            3'b101:  load_data = {16'h0, hsel[15:0]};
            default: load_data = '0;
        endcase
        case (a_size[1:0])
            2'b00: begin
                wmask = 32'h0000_00FF << bsh;
                wsh   = a_wdata << bsh;
            end
            2'b01: begin
                wmask = 32'h0000_FFFF << hsh;
                wsh   = a_wdata << hsh;
            end
            default: begin
                wmask = '1;
                wsh   = a_wdata;
            end
        endcase
        merged = (rd_word & ~wmask) | (wsh & wmask);
        mem_we = enter_resp && a_we && !err && rst_n;
    end

    // Storage is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            req_ready <= (next_state == IDLE);
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || a_we) ? 32'h0 : load_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
